// File: rtl/cc_game_sequencer.sv
// cc_game_sequencer: buffers 46 items, replays them to the CC as a load burst and an action burst,
// then waits for a score (or times out) and reports one result per game.
module cc_game_sequencer #(
    parameter int TIMEOUT = 500,
    parameter int GAP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       item_valid,
    output logic       item_ready,
    input  logic [9:0] item_data,
    output logic       cc_in_valid_1,
    output logic       cc_in_valid_2,
    output logic [2:0] cc_in_color,
    output logic [5:0] cc_in_starting_pos,
    output logic       cc_in_stripe,
    output logic [1:0] cc_in_action,
    input  logic       cc_out_valid,
    input  logic [6:0] cc_out_score,
    output logic       res_valid,
    output logic [6:0] res_score,
    output logic       res_timeout,
    output logic       busy,
    output logic       proto_err,
    output logic [7:0] games_done
);
    typedef enum logic [2:0] {S_FILL, S_LOAD, S_GAP, S_ACT, S_WAIT, S_RESULT} state_t;

    localparam logic [15:0] TO_M1  = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_M1 = 16'(GAP - 1);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [9:0]  mem_q [0:45];
    logic        we;
    logic [5:0]  rd_idx;
    logic [9:0]  rd;
    logic        ready_q, ready_d, busy_q, busy_d, proto_q, proto_d;
    logic        v1_q, v1_d, v2_q, v2_d, stripe_q, stripe_d;
    logic [2:0]  color_q, color_d;
    logic [5:0]  pos_q, pos_d;
    logic [1:0]  action_q, action_d;
    logic        rv_q, rv_d, rto_q, rto_d;
    logic [6:0]  rscore_q, rscore_d;
    logic [7:0]  games_q, games_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        we       = 1'b0;
        rscore_d = '0;
        rto_d    = 1'b0;
        case (state_q)
            S_FILL: if (item_valid && ready_q) begin
                we    = 1'b1;
                idx_d = (idx_q == 6'd45) ? 6'd0 : idx_q + 6'd1;
                if (idx_q == 6'd45) state_d = S_LOAD;
            end
            S_LOAD: begin
                idx_d = (idx_q == 6'd35) ? 6'd0 : idx_q + 6'd1;
                cnt_d = '0;
                if (idx_q == 6'd35) state_d = (GAP == 0) ? S_ACT : S_GAP;
            end
            S_GAP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == GAP_M1) state_d = S_ACT;
            end
            S_ACT: begin
                idx_d = (idx_q == 6'd9) ? 6'd0 : idx_q + 6'd1;
                cnt_d = '0;
                if (idx_q == 6'd9) state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // a score arriving on the timeout cycle still counts as a score
                if (cc_out_valid) begin
                    state_d  = S_RESULT;
                    rscore_d = cc_out_score;
                end else if (cnt_q == TO_M1) begin
                    state_d = S_RESULT;
                    rto_d   = 1'b1;
                end
            end
            S_RESULT: begin
                state_d = S_FILL;
                idx_d   = '0;
                cnt_d   = '0;
            end
            default: state_d = S_FILL;
        endcase
    end

    // outputs are registered from the next state so they line up with the state register
    always_comb begin
        rd_idx   = (state_d == S_ACT) ? idx_d + 6'd36 : idx_d;
        rd       = mem_q[rd_idx];
        v1_d     = state_d == S_LOAD;
        v2_d     = state_d == S_ACT;
        color_d  = v1_d ? rd[2:0] : 3'd0;
        pos_d    = (v1_d && idx_d < 6'd4) ? rd[8:3] : v2_d ? rd[5:0] : 6'd0;
        stripe_d = v1_d && idx_d < 6'd4 && rd[9];
        action_d = v2_d ? rd[7:6] : 2'd0;
        rv_d     = state_d == S_RESULT;
        games_d  = games_q + 8'(rv_d);
        busy_d   = state_d != S_FILL;
        ready_d  = state_d == S_FILL;
        proto_d  = proto_q | (cc_out_valid && state_q != S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[idx_q] <= item_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FILL;
            idx_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            proto_q  <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            color_q  <= '0;
            pos_q    <= '0;
            stripe_q <= 1'b0;
            action_q <= '0;
            rv_q     <= 1'b0;
            rscore_q <= '0;
            rto_q    <= 1'b0;
            games_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            proto_q  <= proto_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            color_q  <= color_d;
            pos_q    <= pos_d;
            stripe_q <= stripe_d;
            action_q <= action_d;
            rv_q     <= rv_d;
            rscore_q <= rscore_d;
            rto_q    <= rto_d;
            games_q  <= games_d;
        end
    end

    assign item_ready         = ready_q;
    assign busy               = busy_q;
    assign proto_err          = proto_q;
    assign cc_in_valid_1      = v1_q;
    assign cc_in_valid_2      = v2_q;
    assign cc_in_color        = color_q;
    assign cc_in_starting_pos = pos_q;
    assign cc_in_stripe       = stripe_q;
    assign cc_in_action       = action_q;
    assign res_valid          = rv_q;
    assign res_score          = rscore_q;
    assign res_timeout        = rto_q;
    assign games_done         = games_q;
endmodule

// File: tb/tb_cc_game_sequencer.sv
// tb_cc_game_sequencer: directed scenario tasks for cc_game_sequencer with inline checks.
module tb_cc_game_sequencer;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       item_valid = 1'b0;
    logic       item_ready;
    logic [9:0] item_data = '0;
    logic       cc_in_valid_1, cc_in_valid_2, cc_in_stripe;
    logic [2:0] cc_in_color;
    logic [5:0] cc_in_starting_pos;
    logic [1:0] cc_in_action;
    logic       cc_out_valid = 1'b0;
    logic [6:0] cc_out_score = '0;
    logic       res_valid, res_timeout, busy, proto_err;
    logic [6:0] res_score;
    logic [7:0] games_done;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_games = '0;
    logic       exp_proto = 1'b0;

    cc_game_sequencer #(.TIMEOUT(TO), .GAP(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .item_valid(item_valid), .item_ready(item_ready), .item_data(item_data),
        .cc_in_valid_1(cc_in_valid_1), .cc_in_valid_2(cc_in_valid_2),
        .cc_in_color(cc_in_color), .cc_in_starting_pos(cc_in_starting_pos),
        .cc_in_stripe(cc_in_stripe), .cc_in_action(cc_in_action),
        .cc_out_valid(cc_out_valid), .cc_out_score(cc_out_score),
        .res_valid(res_valid), .res_score(res_score), .res_timeout(res_timeout),
        .busy(busy), .proto_err(proto_err), .games_done(games_done)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] obs();
        return {cc_in_valid_1, cc_in_valid_2, cc_in_color, cc_in_starting_pos, cc_in_stripe,
                cc_in_action, item_ready, busy, res_valid};
    endfunction

    function automatic logic [16:0] mk(logic v1, logic v2, logic [2:0] col, logic [5:0] pos,
                                       logic str, logic [1:0] act, logic rdy, logic bsy, logic rv);
        return {v1, v2, col, pos, str, act, rdy, bsy, rv};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (obs() !== 17'd0 || proto_err !== 1'b0 || games_done !== 8'd0 || res_score !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h pe=%b gd=%0d rs=%0d, want all zero", obs(), proto_err, games_done, res_score);
        end
        step();
        step();
        checks++;
        if (obs() !== 17'd0) begin
            errors++;
            $display("FAIL reset_held: got %h, want 0", obs());
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 1, 0, 0)) begin
            errors++;
            $display("FAIL reset_release: got %h, want %h", obs(), mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
        end
    endtask

    // stall toggles item_valid; resp<0 means the CC never answers; hold>1 keeps cc_out_valid one extra cycle
    task automatic run_game(input bit stall, input int resp, input int hold, input int seed, input bit abort_act);
        logic [9:0]  items [46];
        logic [9:0]  it;
        logic [6:0]  score;
        logic [16:0] e;
        int          k, cyc, nw;
        bit          hs;
        score = 7'((37 + seed) % 128);
        for (int i = 0; i < 46; i++) items[i] = 10'((i * 37 + seed * 101 + 3) % 1024);
        k = 0;
        cyc = 0;
        while (k < 46 && cyc < 400) begin
            item_valid = stall ? (cyc % 2 == 0) : 1'b1;
            item_data  = items[k];
            hs = item_valid && item_ready;
            step();
            if (hs) k++;
            cyc++;
        end
        item_valid = 1'b0;
        item_data  = '0;
        checks++;
        if (k != 46) begin
            errors++;
            $display("FAIL fill_accept: got %0d items, want 46", k);
            return;
        end
        for (int c = 0; c < 36; c++) begin
            it = items[c];
            e = mk(1, 0, it[2:0], c < 4 ? it[8:3] : 6'd0, c < 4 ? it[9] : 1'b0, 0, 0, 1, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL load_cycle%0d: got %h, want %h", c, obs(), e);
            end
            step();
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 1, 0)) begin
                errors++;
                $display("FAIL gap_cycle%0d: got %h, want %h", c, obs(), mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
            end
            step();
        end
        for (int c = 0; c < 10; c++) begin
            it = items[36 + c];
            e = mk(0, 1, 0, it[5:0], 0, it[7:6], 0, 1, 0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL act_cycle%0d: got %h, want %h", c, obs(), e);
            end
            if (abort_act && c == 5) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (obs() !== 17'd0 || proto_err !== 1'b0 || games_done !== 8'd0) begin
                    errors++;
                    $display("FAIL async_abort: got %h pe=%b gd=%0d, want all zero", obs(), proto_err, games_done);
                end
                step();
                rst_n = 1'b1;
                exp_games = '0;
                exp_proto = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    step();
                    checks++;
                    if (obs() !== mk(0, 0, 0, 0, 0, 0, 1, 0, 0)) begin
                        errors++;
                        $display("FAIL abort_idle%0d: got %h, want %h", j, obs(), mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
                    end
                end
                return;
            end
            step();
        end
        nw = (resp >= 0) ? resp + 1 : TO;
        for (int w = 0; w < nw; w++) begin
            checks++;
            if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 1, 0)) begin
                errors++;
                $display("FAIL wait_cycle%0d: got %h, want %h", w, obs(), mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
            end
            cc_out_valid = (resp >= 0 && w == resp);
            cc_out_score = cc_out_valid ? score : 7'd0;
            step();
        end
        exp_games = exp_games + 8'd1;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 0, 1, 1) || res_score !== (resp >= 0 ? score : 7'd0)
            || res_timeout !== (resp < 0) || games_done !== exp_games) begin
            errors++;
            $display("FAIL result: got %h score=%0d to=%b gd=%0d, want %h score=%0d to=%b gd=%0d",
                     obs(), res_score, res_timeout, games_done, mk(0, 0, 0, 0, 0, 0, 0, 1, 1),
                     resp >= 0 ? score : 7'd0, resp < 0, exp_games);
        end
        cc_out_valid = (resp >= 0 && hold > 1);
        cc_out_score = cc_out_valid ? score + 7'd1 : 7'd0;
        if (cc_out_valid) exp_proto = 1'b1;
        step();
        cc_out_valid = 1'b0;
        cc_out_score = '0;
        checks++;
        if (obs() !== mk(0, 0, 0, 0, 0, 0, 1, 0, 0) || res_score !== 7'd0 || res_timeout !== 1'b0
            || proto_err !== exp_proto) begin
            errors++;
            $display("FAIL after_result: got %h score=%0d to=%b pe=%b, want %h 0 0 pe=%b",
                     obs(), res_score, res_timeout, proto_err, mk(0, 0, 0, 0, 0, 0, 1, 0, 0), exp_proto);
        end
    endtask

    task automatic test_back_to_back();
        run_game(0, 20, 1, 0, 0);
    endtask

    task automatic test_stall();
        run_game(1, 3, 1, 5, 0);
    endtask

    task automatic test_timeout();
        run_game(0, -1, 1, 9, 0);
    endtask

    task automatic test_double_valid();
        run_game(0, 7, 2, 2, 0);
        step();
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky: got %b, want 1", proto_err);
        end
    endtask

    task automatic test_reset_mid_act();
        run_game(0, 0, 1, 4, 1);
        run_game(0, 1, 1, 6, 0);
    endtask

    task automatic test_wrap();
        for (int g = 0; g < 255; g++) run_game(0, 0, 1, g, 0);
        checks++;
        if (games_done !== 8'd0) begin
            errors++;
            $display("FAIL games_wrap: got %0d, want 0", games_done);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_double_valid();
        test_reset_mid_act();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cc_game_sequencer.md
CC_GAME_SEQUENCER -- requirements
Module: cc_game_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 500: max cycles to wait for a score after the action burst.
REQ-002 SHALL have parameter GAP, default 2: idle cycles between the board burst and the action burst.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port item_valid  input  1  upstream item available.
REQ-006 SHALL have port item_ready  output  1  sequencer accepts item this cycle.
REQ-007 SHALL have port item_data  input  10  board item: [2:0] color, [8:3] pos, [9] stripe; action item: [5:0] pos, [7:6] action.
REQ-008 SHALL have ports cc_in_valid_1/cc_in_valid_2  output  1 each  drive the CC load and action phases.
REQ-009 SHALL have ports cc_in_color (3), cc_in_starting_pos (6), cc_in_stripe (1), cc_in_action (2)  output  CC data inputs.
REQ-010 SHALL have ports cc_out_valid (1), cc_out_score (7)  input  CC result.
REQ-011 SHALL have ports res_valid (1), res_score (7), res_timeout (1)  output  per-game result.
REQ-012 SHALL have ports busy (1), proto_err (1), games_done (8)  output  status.

Function
REQ-013 SHALL implement states FILL, LOAD, GAP, ACT, WAIT, RESULT.
REQ-014 FILL: item_ready=1; each item_valid&&item_ready handshake writes item_data to buffer entry idx (0..45), idx increments; entries 0-35 board, 36-45 actions.
REQ-015 On the 46th handshake SHALL go to LOAD next cycle; item_ready SHALL be 0 in all states except FILL.
REQ-016 LOAD: SHALL assert cc_in_valid_1 for exactly 36 consecutive cycles, entry k in cycle k; cc_in_color=entry[2:0] every cycle.
REQ-017 LOAD: cc_in_starting_pos=entry[8:3] and cc_in_stripe=entry[9] in cycles 0-3 only; 0 in cycles 4-35.
REQ-018 GAP: all cc_* outputs 0 for exactly GAP cycles, then ACT.
REQ-019 ACT: SHALL assert cc_in_valid_2 for exactly 10 consecutive cycles; cc_in_starting_pos=entry[5:0], cc_in_action=entry[7:6].
REQ-020 All cc_* outputs SHALL be registered; any data output SHALL be 0 whenever its qualifying valid is low.
REQ-021 WAIT: 9-bit+ counter clears on entry, increments each cycle; cc_out_valid=1 -> capture cc_out_score, go RESULT with res_timeout=0.
REQ-022 WAIT: counter reaching TIMEOUT with cc_out_valid=0 -> RESULT with res_timeout=1, captured score 0; if both occur same cycle, cc_out_valid wins.
REQ-023 RESULT: res_valid=1 for exactly one cycle, res_score=captured value, res_timeout as decided; games_done increments (wraps 255->0); next state FILL with idx=0.
REQ-024 res_score and res_timeout SHALL be 0 whenever res_valid=0.
REQ-025 busy SHALL be 1 in LOAD, GAP, ACT, WAIT, RESULT; 0 in FILL.
REQ-026 proto_err SHALL set (sticky) when cc_out_valid=1 in any state other than WAIT, including the cycle after a captured score; cleared only by reset.
REQ-027 Item stalls (item_valid=0) in FILL SHALL only delay; no bubble SHALL ever appear inside LOAD or ACT bursts.

Reset
REQ-028 rst_n low SHALL immediately force state FILL, idx=0, counter=0, games_done=0, proto_err=0, all cc_* and res_* outputs 0, busy 0; item_ready 1 from the first edge after release.
REQ-029 Reset asserted mid-LOAD/ACT/WAIT SHALL abort the game with no res_valid pulse; buffer contents are not cleared and need not be.

Verification
REQ-030 46 back-to-back items, CC pulses score 37 at WAIT cycle 20 -> 36-cycle valid_1 burst, 2 idle, 10-cycle valid_2 burst, res_valid one cycle with res_score=37, games_done=1.
REQ-031 Items with item_valid toggled 1/0 -> bursts still contiguous 36 and 10 cycles; stripe/pos nonzero only in first 4 load cycles.
REQ-032 CC never responds -> res_valid with res_timeout=1, res_score=0 exactly TIMEOUT cycles after WAIT entry; next FILL accepted.
REQ-033 cc_out_valid held 2 cycles -> score from first cycle reported, proto_err=1 stays set.
REQ-034 rst_n pulsed low during ACT cycle 5 -> cc_in_valid_2 drops asynchronously, no res_valid, item_ready=1 after release.
REQ-035 256 games -> games_done wraps to 0.
